victim_cache_ctrl: RTL and testbench
====================================

# victim_cache_ctrl

Controller for the fully-associative victim cache beside the write-back data cache. It holds tag, valid and dirty state for each victim entry and resolves lookups in the same cycle. It sequences inserts of evicted lines, extracts lines on a victim hit, and swaps the two when both happen together. It writes dirty victims back over the data-memory port and runs a full flush. The line data array is external and is driven from the way-select and write-enable outputs below.

## Interface
- VC_ENTRIES, 4: number of victim entries; power of two, 2..16.
- ADDR_BITS, 28: line-address width (byte address minus line offset).
- WAY_BITS, $clog2(VC_ENTRIES): way-index width (derived).

- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- lookup_req_i  in  1  dcache is probing the victim cache
- lookup_addr_i  in  ADDR_BITS  probed line address
- vc_hit_o  out  1  combinational hit: lookup_req_i & some valid entry matches
- hit_way_o  out  WAY_BITS  matching way; lowest index wins; 0 when no hit
- hit_dirty_o  out  1  dirty bit of the hit entry
- extract_i  in  1  move the hit line into dcache; honoured only with vc_hit_o
- insert_i  in  1  dcache evicts a line into the victim cache; held until accepted
- insert_addr_i  in  ADDR_BITS  evicted line address; stable while insert_i
- insert_dirty_i  in  1  evicted line is dirty
- insert_ready_o  out  1  insert accepted this cycle
- data_we_o  out  1  write the insert line into data array way data_way_o
- data_way_o  out  WAY_BITS  data-array write way
- data_rd_way_o  out  WAY_BITS  data-array read way (hit way, or writeback way)
- vc2mem_req_o  out  1  memory request (writeback)
- vc2mem_wr_o  out  1  memory write
- vc2mem_addr_o  out  ADDR_BITS  writeback line address
- mem2vc_ack_i  in  1  memory ack
- flush_i  in  1  start flush; sampled in IDLE
- flush_done_o  out  1  one-cycle pulse when the flush completes
- kill_i  in  1  abort the ongoing operation
- busy_o  out  1  state != IDLE

## Operation
- State per entry: tag[ADDR_BITS], valid, dirty. Replacement pointer rr_ptr[WAY_BITS].
- States:
  - IDLE: lookups, extracts and inserts are handled here.
  - WB: a dirty victim is being written back.
  - INSERT: write the pending insert into a now-clean way.
  - FLUSH_SCAN, FLUSH_WB, FLUSH_DONE: flush sequence.
- Lookup: purely combinational and valid in every state. extract_i is honoured only in IDLE.
- Extract alone (IDLE): the hit entry's valid and dirty clear at the clock edge. data_rd_way_o = hit_way_o.
- Insert target selection, IDLE only:
  - swap: extract_i & vc_hit_o & insert_i together. Target = hit way. No writeback needed, since the hit line goes to the dcache.
  - else the lowest-index invalid way.
  - else rr_ptr.
- Insert with the target clean or invalid:
  - insert_ready_o = 1, data_we_o = 1, data_way_o = target, all in the same cycle.
  - Entry is written at the edge: tag = insert_addr_i, valid = 1, dirty = insert_dirty_i.
  - rr_ptr increments (wraps modulo VC_ENTRIES) only if the target came from rr_ptr.
- Insert with a dirty victim (target from rr_ptr, valid & dirty):
  - insert_ready_o = 0. The target is latched into wb_way_ff. Go to WB.
  - WB: vc2mem_req_o = vc2mem_wr_o = 1, vc2mem_addr_o = tag[wb_way_ff], data_rd_way_o = wb_way_ff. All held until mem2vc_ack_i.
  - On ack: dirty[wb_way_ff] clears, next state INSERT.
  - INSERT: performs the clean-insert actions on wb_way_ff (ready, we, rr_ptr++), then returns to IDLE.
- Flush (flush_i in IDLE; flush has priority over insert):
  - FLUSH_SCAN: look at idx. If valid & dirty, go to FLUSH_WB. Otherwise valid[idx] clears; if idx is the last entry go to FLUSH_DONE, else idx++.
  - FLUSH_WB: memory write of entry idx, same as WB. On ack, valid and dirty clear, back to FLUSH_SCAN with idx++ (or to FLUSH_DONE if idx was the last entry).
  - FLUSH_DONE: flush_done_o = 1, idx resets to 0, next state IDLE.
- kill_i, any state:
  - Next state IDLE. vc2mem_req_o is forced to 0 that cycle; insert_ready_o and data_we_o are forced to 0.
  - Arrays keep their current contents; a writeback without an ack leaves dirty set. The pending insert is dropped; dcache re-issues it.
- Memory ack outside WB or FLUSH_WB is ignored.

## Timing
- Reset: all valid and dirty bits = 0, rr_ptr = 0, state IDLE.
- Outputs during reset: every output is 0. vc_hit_o is 0 because no entry is valid.
- Hit: 0-cycle (combinational). Extract takes effect at the next edge.
- Clean insert: accepted the same cycle, 0 stall.
- Dirty-victim insert: insert_ready_o rises at the earliest 2 cycles after insert_i, i.e. the cycle after ack.
- Lookup of an address being inserted in the same cycle misses. The new entry is visible from the next cycle.
- Swap updates the hit way's tag in one edge. A lookup of the old address in the next cycle misses.
- Flush of N entries with D dirty ones: N + D + (cycles waiting for acks) + 1 cycles.

## Test plan
- Reset, then lookup_addr 0x0000100 -> vc_hit_o = 0. After insert 0x0000100 (clean) -> next cycle hit, hit_way_o = 0, valid = 4'b0001, rr_ptr = 0.
- Fill ways 0..3 with 0x10..0x13, where 0x12 is dirty and rr_ptr has reached 2. Insert 0x20:
  - insert_ready_o = 0.
  - vc2mem_req/wr = 1 with addr 0x12 until ack.
  - The cycle after ack: data_we_o = 1, way 2, tag 0x20 clean, rr_ptr = 3.
- Swap: hit on 0x11 (way 1) with extract_i & insert_i of 0x30, dirty -> same cycle insert_ready_o = 1, data_way_o = 1. Next cycle 0x11 misses, 0x30 hits dirty.
- Flush with ways 0 and 3 dirty, acks after 3 cycles each:
  - Exactly two memory writes, addresses tag0 then tag3.
  - Then flush_done_o pulses once, all valid = 0, back in IDLE.
- kill_i in the second WB cycle -> vc2mem_req_o = 0 that cycle, IDLE next, dirty bit of the victim is still 1, no data_we_o.
- Extract alone on way 2 -> valid[2] clears. A following clean insert targets way 2, the lowest invalid way, and rr_ptr is unchanged.

Source files
------------

// File: rtl/victim_cache_ctrl.sv
// victim_cache_ctrl: tag/valid/dirty state and sequencing for a fully-associative victim cache.
// Lookups resolve combinationally; inserts, swaps, dirty writebacks and flushes are sequenced here.
module victim_cache_ctrl #(
    parameter int VC_ENTRIES = 4,
    parameter int ADDR_BITS  = 28,
    parameter int WAY_BITS   = $clog2(VC_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lookup_req_i,
    input  logic [ADDR_BITS-1:0] lookup_addr_i,
    output logic                 vc_hit_o,
    output logic [WAY_BITS-1:0]  hit_way_o,
    output logic                 hit_dirty_o,
    input  logic                 extract_i,
    input  logic                 insert_i,
    input  logic [ADDR_BITS-1:0] insert_addr_i,
    input  logic                 insert_dirty_i,
    output logic                 insert_ready_o,
    output logic                 data_we_o,
    output logic [WAY_BITS-1:0]  data_way_o,
    output logic [WAY_BITS-1:0]  data_rd_way_o,
    output logic                 vc2mem_req_o,
    output logic                 vc2mem_wr_o,
    output logic [ADDR_BITS-1:0] vc2mem_addr_o,
    input  logic                 mem2vc_ack_i,
    input  logic                 flush_i,
    output logic                 flush_done_o,
    input  logic                 kill_i,
    output logic                 busy_o
);
    typedef enum logic [2:0] {S_IDLE, S_WB, S_INSERT, S_FSCAN, S_FWB, S_FDONE} state_t;

    state_t                r_state, w_next;
    logic [ADDR_BITS-1:0]  r_tag [VC_ENTRIES];
    logic [VC_ENTRIES-1:0] r_valid, r_dirty;
    logic [WAY_BITS-1:0]   r_rr, r_wb_way, r_idx;
    logic                  w_match, w_inv_any, w_hit, w_swap, w_from_rr, w_victim_dirty;
    logic                  w_idle, w_we, w_extract, w_wb, w_last, w_idx_dirty;
    logic [WAY_BITS-1:0]   w_match_way, w_inv_way, w_tgt, w_we_way, w_wb_way;

    // Descending scan so the lowest matching / invalid way is the one left standing.
    always_comb begin
        w_match     = 1'b0;
        w_match_way = '0;
        w_inv_any   = 1'b0;
        w_inv_way   = '0;
        for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && r_tag[i] == lookup_addr_i) begin
                w_match     = 1'b1;
                w_match_way = WAY_BITS'(i);
            end
            if (!r_valid[i]) begin
                w_inv_any = 1'b1;
                w_inv_way = WAY_BITS'(i);
            end
        end
    end

    always_comb begin
        w_idle         = r_state == S_IDLE;
        w_hit          = rst_n & lookup_req_i & w_match;
        w_swap         = extract_i & w_hit & insert_i;
        w_from_rr      = !w_swap & !w_inv_any;
        w_tgt          = w_swap ? w_match_way : (w_inv_any ? w_inv_way : r_rr);
        w_victim_dirty = w_from_rr & r_valid[r_rr] & r_dirty[r_rr];
        w_we           = rst_n & !kill_i & ((r_state == S_INSERT) |
                         (w_idle & insert_i & !flush_i & !w_victim_dirty));
        w_we_way       = (r_state == S_INSERT) ? r_wb_way : w_tgt;
        w_extract      = rst_n & !kill_i & w_idle & extract_i & w_hit;
        w_wb           = rst_n & ((r_state == S_WB) | (r_state == S_FWB));
        w_wb_way       = (r_state == S_WB) ? r_wb_way : r_idx;
        w_last         = r_idx == WAY_BITS'(VC_ENTRIES - 1);
        w_idx_dirty    = r_valid[r_idx] & r_dirty[r_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = flush_i ? S_FSCAN : ((insert_i & w_victim_dirty) ? S_WB : S_IDLE);
            S_WB:     w_next = mem2vc_ack_i ? S_INSERT : S_WB;
            S_INSERT: w_next = S_IDLE;
            S_FSCAN:  w_next = w_idx_dirty ? S_FWB : (w_last ? S_FDONE : S_FSCAN);
            S_FWB:    w_next = !mem2vc_ack_i ? S_FWB : (w_last ? S_FDONE : S_FSCAN);
            default:  w_next = S_IDLE;
        endcase
        if (kill_i) w_next = S_IDLE;
    end

    always_comb begin
        vc_hit_o       = w_hit;
        hit_way_o      = w_hit ? w_match_way : '0;
        hit_dirty_o    = w_hit & r_dirty[w_match_way];
        insert_ready_o = w_we;
        data_we_o      = w_we;
        data_way_o     = w_we ? w_we_way : '0;
        data_rd_way_o  = w_wb ? w_wb_way : hit_way_o;
        vc2mem_req_o   = w_wb & !kill_i;
        vc2mem_wr_o    = vc2mem_req_o;
        vc2mem_addr_o  = vc2mem_req_o ? r_tag[w_wb_way] : '0;
        flush_done_o   = rst_n & (r_state == S_FDONE);
        busy_o         = rst_n & (r_state != S_IDLE);
    end

    // Extract clears before the insert write so a swap leaves the new line valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= '0;
            r_dirty  <= '0;
            r_rr     <= '0;
            r_wb_way <= '0;
            r_idx    <= '0;
        end else if (kill_i) begin
            r_idx <= '0;
        end else begin
            if (w_extract) begin
                r_valid[w_match_way] <= 1'b0;
                r_dirty[w_match_way] <= 1'b0;
            end
            if (w_we) begin
                r_tag[w_we_way]   <= insert_addr_i;
                r_valid[w_we_way] <= 1'b1;
                r_dirty[w_we_way] <= insert_dirty_i;
            end
            if (w_we && ((r_state == S_INSERT) || w_from_rr)) r_rr <= r_rr + WAY_BITS'(1);
            if (w_idle && insert_i && w_victim_dirty) r_wb_way <= r_rr;
            if (w_wb && mem2vc_ack_i) r_dirty[w_wb_way] <= 1'b0;
            if (r_state == S_FWB && mem2vc_ack_i) r_valid[r_idx] <= 1'b0;
            if (r_state == S_FSCAN && !w_idx_dirty) r_valid[r_idx] <= 1'b0;
            // Index wraps to 0 after the last entry since VC_ENTRIES is a power of two.
            if ((r_state == S_FSCAN && !w_idx_dirty) || (r_state == S_FWB && mem2vc_ack_i))
                r_idx <= r_idx + WAY_BITS'(1);
        end
    end
endmodule

// File: tb/tb_victim_cache_ctrl.sv
// tb_victim_cache_ctrl: directed stimulus with queued expectations checked by a negedge monitor.
module tb_victim_cache_ctrl;
    localparam int AB = 28;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          lookup_req_i = 1'b0, extract_i = 1'b0, insert_i = 1'b0, insert_dirty_i = 1'b0;
    logic          mem2vc_ack_i = 1'b0, flush_i = 1'b0, kill_i = 1'b0;
    logic [AB-1:0] lookup_addr_i = '0, insert_addr_i = '0, vc2mem_addr_o;
    logic          vc_hit_o, hit_dirty_o, insert_ready_o, data_we_o;
    logic          vc2mem_req_o, vc2mem_wr_o, flush_done_o, busy_o;
    logic [1:0]    hit_way_o, data_way_o, data_rd_way_o;

    int checks = 0, passed = 0, ack_delay = 2, ack_cnt = 0, done_exp = 0, n = 0;
    logic [3:0]    lk_q [$];
    logic [1:0]    we_q [$];
    logic [AB-1:0] mem_q [$];

    victim_cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_req_i(lookup_req_i), .lookup_addr_i(lookup_addr_i),
        .vc_hit_o(vc_hit_o), .hit_way_o(hit_way_o), .hit_dirty_o(hit_dirty_o),
        .extract_i(extract_i), .insert_i(insert_i), .insert_addr_i(insert_addr_i),
        .insert_dirty_i(insert_dirty_i), .insert_ready_o(insert_ready_o),
        .data_we_o(data_we_o), .data_way_o(data_way_o), .data_rd_way_o(data_rd_way_o),
        .vc2mem_req_o(vc2mem_req_o), .vc2mem_wr_o(vc2mem_wr_o), .vc2mem_addr_o(vc2mem_addr_o),
        .mem2vc_ack_i(mem2vc_ack_i), .flush_i(flush_i), .flush_done_o(flush_done_o),
        .kill_i(kill_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [3:0] lk(input logic h, input logic [1:0] w, input logic d);
        return {h, w, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [AB-1:0] a, input logic ext, input logic [3:0] exp);
        lookup_req_i = 1'b1; lookup_addr_i = a; extract_i = ext;
        lk_q.push_back(exp);
        step();
        lookup_req_i = 1'b0; extract_i = 1'b0;
    endtask

    task automatic insert(input logic [AB-1:0] a, input logic d, input logic [1:0] w);
        insert_i = 1'b1; insert_addr_i = a; insert_dirty_i = d;
        we_q.push_back(w);
        step();
        insert_i = 1'b0;
    endtask

    // Memory model: acks the ack_delay-th cycle of a held request.
    initial forever begin
        @(posedge clk);
        #2;
        if (mem2vc_ack_i) begin
            mem2vc_ack_i = 1'b0;
            ack_cnt = 0;
        end else if (vc2mem_req_o) begin
            ack_cnt++;
            if (ack_cnt >= ack_delay) mem2vc_ack_i = 1'b1;
        end else ack_cnt = 0;
    end

    always @(negedge clk) begin
        logic [3:0] e;
        logic [1:0] w;
        if (rst_n && lookup_req_i && lk_q.size() != 0) begin
            e = lk_q.pop_front();
            chk("lookup", 32'({vc_hit_o, hit_way_o, hit_dirty_o}), 32'(e));
        end
        if (data_we_o) begin
            if (we_q.size() == 0) chk("we_unexpected", 32'(data_we_o), 0);
            else begin
                w = we_q.pop_front();
                chk("we_way", 32'({insert_ready_o, data_way_o}), 32'({1'b1, w}));
            end
        end
        if (vc2mem_req_o) begin
            if (mem_q.size() == 0) chk("mem_unexpected", 32'(vc2mem_req_o), 0);
            else begin
                chk("mem_wr_addr", 32'({vc2mem_wr_o, vc2mem_addr_o}), 32'({1'b1, mem_q[0]}));
                if (mem2vc_ack_i) void'(mem_q.pop_front());
            end
        end
        if (flush_done_o) begin
            if (done_exp == 0) chk("done_unexpected", 32'(flush_done_o), 0);
            else begin
                done_exp--;
                chk("flush_done", 32'({flush_done_o, vc2mem_req_o}), 32'b10);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        // Reset with requests applied: every output must stay low.
        lookup_req_i = 1'b1; lookup_addr_i = 28'h100; insert_i = 1'b1; insert_addr_i = 28'h100;
        step(); step();
        chk("reset_outs", 32'({vc_hit_o, insert_ready_o, data_we_o, busy_o, vc2mem_req_o,
                               flush_done_o, hit_way_o, data_way_o}), 0);
        lookup_req_i = 1'b0; insert_i = 1'b0; rst_n = 1'b1;
        step();

        // Same-cycle lookup of the line being inserted misses; visible next cycle.
        lookup_req_i = 1'b1; lookup_addr_i = 28'h100; insert_i = 1'b1; insert_addr_i = 28'h100;
        insert_dirty_i = 1'b0; lk_q.push_back(lk(0, 0, 0)); we_q.push_back(2'd0);
        step();
        lookup_req_i = 1'b0; insert_i = 1'b0;
        lookup(28'h100, 0, lk(1, 0, 0));
        lookup(28'h101, 0, lk(0, 0, 0));

        // Build ways 0x10..0x13 with 0x12 dirty and rr at 2.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        insert(28'h40, 0, 2'd0); insert(28'h41, 0, 2'd1);
        insert(28'h42, 0, 2'd2); insert(28'h43, 0, 2'd3);
        insert(28'h10, 0, 2'd0); insert(28'h11, 0, 2'd1);
        lookup(28'h42, 1, lk(1, 2, 0));
        lookup(28'h42, 0, lk(0, 0, 0));
        insert(28'h12, 1, 2'd2);
        lookup(28'h43, 1, lk(1, 3, 0));
        insert(28'h13, 0, 2'd3);
        lookup(28'h12, 0, lk(1, 2, 1));

        // Dirty victim: stall, writeback of 0x12, insert the cycle after ack.
        ack_delay = 2;
        insert_i = 1'b1; insert_addr_i = 28'h20; insert_dirty_i = 1'b0;
        we_q.push_back(2'd2); mem_q.push_back(28'h12);
        #1;
        chk("dirty_insert_stall", 32'(insert_ready_o), 0);
        n = 0;
        while (!insert_ready_o && n < 20) begin step(); n++; end
        chk("dirty_insert_latency", n, 3);
        step();
        insert_i = 1'b0;
        lookup(28'h20, 0, lk(1, 2, 0));
        lookup(28'h12, 0, lk(0, 0, 0));

        // Swap: hit on 0x11 with a dirty insert of 0x30.
        lookup_req_i = 1'b1; lookup_addr_i = 28'h11; extract_i = 1'b1;
        insert_i = 1'b1; insert_addr_i = 28'h30; insert_dirty_i = 1'b1;
        lk_q.push_back(lk(1, 1, 0)); we_q.push_back(2'd1);
        #1;
        chk("swap_ready", 32'(insert_ready_o), 1);
        step();
        lookup_req_i = 1'b0; extract_i = 1'b0; insert_i = 1'b0;
        lookup(28'h11, 0, lk(0, 0, 0));
        lookup(28'h30, 0, lk(1, 1, 1));

        // rr is 3: clean way 3 replaced at once, then way 0; leaves ways 0 and 3 dirty.
        insert(28'h50, 1, 2'd3);
        insert(28'h60, 1, 2'd0);
        lookup(28'h30, 1, lk(1, 1, 1));

        // Flush: writes 0x60 then 0x50, 4 + 2 + 4 + 1 busy cycles.
        ack_delay = 3;
        mem_q.push_back(28'h60); mem_q.push_back(28'h50); done_exp = 1;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        n = 0;
        while (busy_o && n < 100) begin n++; step(); end
        chk("flush_cycles", n, 11);
        lookup(28'h60, 0, lk(0, 0, 0));
        lookup(28'h20, 0, lk(0, 0, 0));
        lookup(28'h50, 0, lk(0, 0, 0));

        // Kill in the second writeback cycle: no request, dirty kept, no insert.
        insert(28'h70, 0, 2'd0); insert(28'h71, 1, 2'd1);
        insert(28'h72, 0, 2'd2); insert(28'h73, 0, 2'd3);
        ack_delay = 5;
        insert_i = 1'b1; insert_addr_i = 28'h80; insert_dirty_i = 1'b0;
        mem_q.push_back(28'h71);
        step(); step();
        kill_i = 1'b1; insert_i = 1'b0;
        #1;
        chk("kill_req", 32'(vc2mem_req_o), 0);
        step();
        kill_i = 1'b0;
        void'(mem_q.pop_front());
        chk("kill_idle", 32'(busy_o), 0);
        lookup(28'h71, 0, lk(1, 1, 1));
        lookup(28'h80, 0, lk(0, 0, 0));

        step(); step();
        chk("lookups_left", lk_q.size(), 0);
        chk("writes_left", we_q.size(), 0);
        chk("mem_left", mem_q.size(), 0);
        chk("done_left", done_exp, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
